// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-stage parameters and the physical register index type.
package phys_reg_free_list_pkg;
  localparam int PR_WIDTH = 6;
  localparam int NUM_PR   = 64;   // must equal 2**PR_WIDTH
  localparam int NUM_AR   = 32;

  typedef logic [PR_WIDTH-1:0] pr_idx_t;
endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers: rename pops at head, commit pushes
// displaced mappings at tail, flush rewinds head to the retirement point.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  localparam int FL_DEPTH = NUM_PR - NUM_AR,
  localparam int PTR_W    = $clog2(FL_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_ready,
  output logic [PR_WIDTH-1:0] alloc_pd,
  input  logic                commit_valid,
  input  logic [PR_WIDTH-1:0] commit_old_pd,
  input  logic                flush,
  output logic [PTR_W-1:0]    free_count,
  output logic                empty
);

  localparam int IDX_W = PTR_W - 1;

  pr_idx_t          storage [FL_DEPTH];
  logic [PTR_W-1:0] head, retire_head, tail;
  logic [PTR_W-1:0] retire_head_nxt;
  logic             do_alloc;

  // Outputs come only from registered state.
  assign free_count  = tail - head;
  assign empty       = (free_count == '0);
  assign alloc_ready = !empty;
  assign alloc_pd    = storage[head[IDX_W-1:0]];

  assign do_alloc        = alloc_req && alloc_ready && !flush;
  assign retire_head_nxt = retire_head + PTR_W'(commit_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      retire_head <= '0;
      tail        <= PTR_W'(FL_DEPTH);
    end else begin
      retire_head <= retire_head_nxt;
      if (commit_valid)
        tail <= tail + 1'b1;
      // Commit is older than the flush, so head rewinds past it.
      if (flush)
        head <= retire_head_nxt;
      else if (do_alloc)
        head <= head + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        storage[i] <= pr_idx_t'(NUM_AR + i);
    end else if (commit_valid) begin
      storage[tail[IDX_W-1:0]] <= commit_old_pd;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: vector table plus corner-case sequences.
module tb_phys_reg_free_list;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_ready;
  logic [5:0] alloc_pd;
  logic       commit_valid = 1'b0;
  logic [5:0] commit_old_pd = '0;
  logic       flush = 1'b0;
  logic [5:0] free_count;
  logic       empty;

  int errors = 0;
  int checks = 0;

  phys_reg_free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_pd(alloc_pd), .commit_valid(commit_valid), .commit_old_pd(commit_old_pd),
    .flush(flush), .free_count(free_count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       c;
    logic [5:0] pd;
    logic       f;
    logic       ready;
    int         exp_pd;
    int         cnt;
    logic       emp;
    logic       chk_pd;
  } vec_t;

  vec_t vecs [35];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic c, input logic [5:0] pd, input logic f);
    @(negedge clk);
    alloc_req = a; commit_valid = c; commit_old_pd = pd; flush = f;
    @(posedge clk);
    #1;
    alloc_req = 1'b0; commit_valid = 1'b0; commit_old_pd = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_state(input string tag, input int cnt, input int pd);
    check({tag, " free_count"}, int'(free_count), cnt);
    check({tag, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
    check({tag, " alloc_ready"}, int'(alloc_ready), (cnt != 0) ? 1 : 0);
    if (cnt != 0) check({tag, " alloc_pd"}, int'(alloc_pd), pd);
  endtask

  initial begin
    // Table: 32 allocations drain the list, a 33rd is ignored, then a commit refills.
    for (int i = 0; i < 32; i++)
      vecs[i] = '{a:1'b1, c:1'b0, pd:6'd0, f:1'b0, ready:(i != 31),
                  exp_pd:33 + i, cnt:31 - i, emp:(i == 31), chk_pd:(i != 31)};
    vecs[32] = '{a:1'b1, c:1'b0, pd:6'd0, f:1'b0, ready:1'b0, exp_pd:0, cnt:0, emp:1'b1, chk_pd:1'b0};
    vecs[33] = '{a:1'b0, c:1'b1, pd:6'd5, f:1'b0, ready:1'b1, exp_pd:5, cnt:1, emp:1'b0, chk_pd:1'b1};
    vecs[34] = '{a:1'b1, c:1'b0, pd:6'd0, f:1'b0, ready:1'b0, exp_pd:0, cnt:0, emp:1'b1, chk_pd:1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_state("reset", 32, 32);

    for (int i = 0; i < 35; i++) begin
      drive(vecs[i].a, vecs[i].c, vecs[i].pd, vecs[i].f);
      check($sformatf("vec%0d free_count", i), int'(free_count), vecs[i].cnt);
      check($sformatf("vec%0d empty", i), int'(empty), int'(vecs[i].emp));
      check($sformatf("vec%0d alloc_ready", i), int'(alloc_ready), int'(vecs[i].ready));
      if (vecs[i].chk_pd)
        check($sformatf("vec%0d alloc_pd", i), int'(alloc_pd), vecs[i].exp_pd);
    end

    // Allocate 10, commit 1..3, flush: head rewinds to retire point.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 6'd0, 1'b0);
    check_state("alloc10", 22, 42);
    for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, 6'(i), 1'b0);
    drive(1'b1, 1'b0, 6'd0, 1'b1);
    check_state("flush", 32, 35);
    for (int i = 0; i < 32; i++) begin
      int exp;
      exp = (i < 29) ? 35 + i : i - 28;
      check($sformatf("post-flush pd%0d", i), int'(alloc_pd), exp);
      drive(1'b1, 1'b0, 6'd0, 1'b0);
    end
    check_state("post-flush drained", 0, 0);

    // Alloc + commit in the same cycle keeps free_count.
    do_reset();
    for (int i = 0; i < 28; i++) drive(1'b1, 1'b0, 6'd0, 1'b0);
    check_state("alloc28", 4, 60);
    drive(1'b1, 1'b1, 6'd7, 1'b0);
    check_state("alloc+commit", 4, 61);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 6'd0, 1'b0);
    check_state("reach committed", 1, 7);

    // Commit + flush in the same cycle: head lands after the committed slot.
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 6'd0, 1'b0);
    drive(1'b0, 1'b1, 6'd9, 1'b1);
    check_state("commit+flush", 32, 33);
    for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, 6'd0, 1'b0);
    check_state("commit+flush wrap", 1, 9);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, 6'(i), 1'b0);
    check_state("pre-rst", 17, 52);
    #2 rst = 1'b1;
    #1;
    check_state("async rst", 32, 32);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 6'd0, 1'b0);
    check_state("after rst alloc", 31, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Allocator for the physical register file that feeds the rename stage. Supplies the `pd` written into the rename map on every renamed instruction with `rd != 0`.
- Storage is a circular FIFO of free physical register indices:
  - Rename dequeues from the head.
  - Commit enqueues the previously committed mapping of the retiring `rd`, which the retirement map has just displaced.
- A retire-head pointer lets a flush return every speculatively allocated register in one cycle, consistent with the rename map being restored from the retirement map.

Parameters:
- PR_WIDTH, 6, physical register index width.
- NUM_PR, 64, total physical registers (must equal 2**PR_WIDTH).
- NUM_AR, 32, architectural registers; physical registers 0..NUM_AR-1 are the reset mappings.
- FL_DEPTH, NUM_PR-NUM_AR (32), free-list entries; must be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_req  in  1  rename consumes `alloc_pd` this cycle.
- alloc_ready  out  1  free list non-empty; `alloc_pd` is valid.
- alloc_pd  out  PR_WIDTH  physical register at the head.
- commit_valid  in  1  an instruction with `rd != 0` retires this cycle.
- commit_old_pd  in  PR_WIDTH  register displaced from the retirement map by that commit.
- flush  in  1  pipeline flush; restores the speculative head.
- free_count  out  $clog2(FL_DEPTH)+1  number of allocatable entries.
- empty  out  1  `free_count == 0`.

Behaviour:
- Pointers `head`, `retire_head` and `tail` are each $clog2(FL_DEPTH)+1 bits, with the MSB as the wrap bit. Index = low bits.
- Reset (async, any cycle, including mid-operation):
  - storage[i] = NUM_AR+i.
  - head = 0, retire_head = 0, tail = FL_DEPTH (wrap bit 1, index 0).
  - free_count = FL_DEPTH, alloc_ready = 1, empty = 0, alloc_pd = NUM_AR.
- free_count = tail - head (modular, full width). alloc_ready = !empty. alloc_pd = storage[head index].
  - All outputs derive from registered state only; there is no combinational path from alloc_req or commit_valid to any output.
- Allocation: alloc_req && alloc_ready && !flush -> head += 1 at the clock edge.
  - alloc_req while empty is ignored; no state change.
  - The consumer must not sample alloc_pd when alloc_ready = 0.
- Commit: commit_valid -> storage[tail index] <= commit_old_pd; tail += 1; retire_head += 1.
  - One commit per cycle, one-cycle latency.
  - A committed entry is visible at alloc_pd on the next cycle if head reaches it. There is no same-cycle bypass when empty.
- Invariants:
  - (tail - retire_head) == FL_DEPTH always; a commit therefore never overwrites an unallocated or in-flight entry.
  - head lies between retire_head and tail.
- Flush: head <= retire_head (after any same-cycle commit increment).
  - free_count becomes FL_DEPTH the next cycle.
  - Allocation in the flush cycle is dropped.
- Simultaneous commit + flush: commit is older and is applied first. retire_head and tail both advance, then head takes the new retire_head value.
- Simultaneous alloc + commit (no flush): both apply; free_count is unchanged.
- Wrap-around: index bits wrap naturally at FL_DEPTH; the wrap bit distinguishes full from empty.
- Assertions (bench/simulation only):
  - commit_valid never asserted with commit_old_pd below... none; commit_old_pd is any value except when it equals a currently free entry (no double free).
  - commit_valid never asserted when retire_head == head (commit without a prior allocation).

Decomposition:
- PR_WIDTH, NUM_PR and NUM_AR live in the shared params package; FL_DEPTH and the pointer width are derived locally.
- No sub-module: single module with the storage array and three pointer registers.
- Shared package type: `pr_idx_t` (logic [PR_WIDTH-1:0]).

Test Plan:
- Reset then 32 consecutive alloc_req -> alloc_pd sequence 32,33,...,63.
  - After the last allocation: empty = 1, alloc_ready = 0, free_count = 0.
  - A 33rd alloc_req is ignored; head is unchanged.
- With the list empty, commit_valid with commit_old_pd = 5 -> next cycle alloc_ready = 1, alloc_pd = 5, free_count = 1.
- Allocate 10 (pd 32..41), commit 3 (old_pd 1,2,3), then flush -> next cycle free_count = 32 and alloc_pd = 35.
  - The following 32 allocations return 35..63, then 1, 2, 3.
- Same cycle alloc_req + commit_valid (old_pd 7) with free_count = 4 -> free_count stays 4; alloc_pd advances by one.
- Same cycle commit_valid (old_pd 9) + flush after 6 allocations -> next cycle free_count = 32, tail advanced by 1, head equals retire_head.
- Assert rst mid-stream after 20 allocations and 5 commits -> outputs immediately (asynchronously) return to: alloc_pd = 32, free_count = 32, empty = 0.
